shift_reg_bank: RTL and testbench
=================================

Name: shift_reg_bank

Overview:
- Parametrised multi-bit register built from the team's single-bit flip-flop concept (CK, D, Q, QN), generalised in width and operating mode.
- Supports hold, parallel load, shift right and shift left, with serial in/out, a synchronous reset value, and a shift-completion counter.
- Used as a serializer/deserializer and a general pipeline register in small SOI digital blocks built from the standard-cell library.

Parameters:
- WIDTH, 8, number of register bits (>= 2).
- RST_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.
- CNT_W, $clog2(WIDTH+1), width of the shift counter. Derived; do not override.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous reset, active-high.
- EN  input  1  clock enable; when 0, all state holds.
- M  input  2  mode select: 00 hold, 01 parallel load, 10 shift right, 11 shift left.
- D  input  WIDTH  parallel load data.
- SI  input  1  serial input.
- Q  output  WIDTH  register contents.
- QN  output  WIDTH  bitwise inverse of Q.
- SO  output  1  serial output: Q[0] in shift-right mode, Q[WIDTH-1] otherwise.
- CNT  output  CNT_W  number of shifts since the last load or reset, saturating at WIDTH.
- DONE  output  1  one-cycle pulse when CNT transitions from WIDTH-1 to WIDTH.

Behaviour:
- Reset, sampled on the CK rising edge when R=1:
  - Q=RST_VAL, QN=~RST_VAL, CNT=0, DONE=0.
  - R has priority over EN and M.
- EN=0 (and R=0):
  - Q and CNT hold.
  - DONE=0 on the next edge.
- EN=1, M=00: Q holds, CNT holds, DONE=0.
- EN=1, M=01: Q<=D, CNT<=0, DONE=0.
- EN=1, M=10: Q<={SI, Q[WIDTH-1:1]} (SI enters the MSB).
- EN=1, M=11: Q<={Q[WIDTH-2:0], SI} (SI enters the LSB).
- Counter rule, shift modes only:
  - CNT<=CNT+1 if CNT<WIDTH; otherwise CNT holds at WIDTH. Shifting continues after saturation.
- DONE rule:
  - DONE is registered and is 1 exactly on the cycle after the edge where CNT went WIDTH-1 -> WIDTH; otherwise 0.
  - Saturated shifts do not re-pulse DONE.
  - Only a load or reset rearms it.
- QN is always combinationally ~Q; there is no separate storage.
- SO is combinational from the current Q and M. M=00/01 selects Q[WIDTH-1].
- Latency:
  - Q, CNT and DONE each reflect an operation one edge after it is sampled.
  - There is no combinational path from D or SI to Q.
- A mode change mid-sequence (e.g. shift right to shift left) does not clear CNT. Only a load or reset clears it.
- Reset asserted mid-sequence aborts it: CNT=0, no DONE pulse.
- Any X on M while EN=1 drives Q to X (simulation only). No X-pessimism masking.

Decomposition:
- Shared package shift_reg_pkg:
  - Mode constants MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHR=2'b10, MODE_SHL=2'b11.
  - Typedef mode_t (2-bit).
- Sub-module shift_reg_bit: one bit slice.
  - Inputs: CK, R, EN, M, D, left-neighbour, right-neighbour, reset bit.
  - 4:1 next-state mux plus a synchronous-reset flop.
  - Instantiated WIDTH times via generate.
  - End slices take SI as the neighbour.
- The counter and DONE logic live in the top module.

Test Plan:
- Reset: R=1 for 1 cycle with WIDTH=8, RST_VAL=8'hA5 -> Q=8'hA5, QN=8'h5A, CNT=0, DONE=0. R=1 together with M=01, D=8'hFF -> Q stays 8'hA5.
- Load then shift right: load D=8'h81, then 8 cycles of M=10 with SI=0 -> SO sequence 1,0,0,0,0,0,0,1. After the shifts Q=8'h00, CNT=8. DONE=1 only on the cycle after the 8th shift.
- Shift left deserialize: after a load of 0, shift SI bits 1,1,0,1,0,0,1,0 with M=11 -> Q=8'hD2, DONE pulses once. A 9th shift gives CNT=8 and no second DONE.
- Enable gating: load 8'h3C, then M=10 with EN=0 for 5 cycles -> Q=8'h3C, CNT=0. EN=1 for one cycle with SI=1 -> Q=8'h9E, CNT=1.
- Mid-sequence events:
  - Reset after 3 shifts -> CNT=0, no DONE.
  - Load after 7 shifts -> CNT=0, no DONE.
  - Switching mode 10 -> 11 after 4 shifts, then 4 more shifts -> DONE after 8 shifts total.
- Parameter sweep: WIDTH=2 and WIDTH=33 with the random mode/EN/SI stream compared against a behavioural model -> no Q, CNT or DONE mismatch over 10k cycles.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the shift register bank.
// Imported by the bit slice and the top.
package shift_reg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_LOAD = 2'b01;
  localparam mode_t MODE_SHR  = 2'b10;
  localparam mode_t MODE_SHL  = 2'b11;

endpackage

// File: rtl/shift_reg_bit.sv
// One bit slice: 4:1 next-state mux feeding a flop
// with synchronous active-high reset.
module shift_reg_bit
  import shift_reg_pkg::*;
(
  input  logic  CK,
  input  logic  R,
  input  logic  EN,
  input  mode_t M,
  input  logic  D,
  input  logic  L,
  input  logic  RN,
  input  logic  RB,
  output logic  Q
);

  logic q_q;
  logic q_d;

  // L is the higher neighbour (shift right), RN the lower (shift left)
  always_comb begin
    q_d = q_q;
    if (EN) begin
      case (M)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = D;
        MODE_SHR:  q_d = L;
        MODE_SHL:  q_d = RN;
        default:   q_d = 1'bx;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (R) q_q <= RB;
    else   q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/shift_reg_bank.sv
// Multi-mode shift register bank: hold/load/shift
// right/shift left, with saturating shift counter and DONE.
module shift_reg_bank
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = $clog2(WIDTH+1)
) (
  input  logic             CK,
  input  logic             R,
  input  logic             EN,
  input  mode_t            M,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic [CNT_W-1:0] CNT,
  output logic             DONE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] l_nb;
  logic [WIDTH-1:0] r_nb;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // End slices take SI as their outer neighbour
  assign l_nb = {SI, Q[WIDTH-1:1]};
  assign r_nb = {Q[WIDTH-2:0], SI};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    shift_reg_bit u_bit (
      .CK (CK),
      .R  (R),
      .EN (EN),
      .M  (M),
      .D  (D[i]),
      .L  (l_nb[i]),
      .RN (r_nb[i]),
      .RB (RST_VAL[i]),
      .Q  (Q[i])
    );
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (EN) begin
      case (M)
        MODE_LOAD: cnt_d = '0;
        MODE_SHR, MODE_SHL: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d  = cnt_q + CNT_ONE;
            done_d = (cnt_q == CNT_MAX - CNT_ONE);
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (R) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign QN   = ~Q;
  assign SO   = (M == MODE_SHR) ? Q[0] : Q[WIDTH-1];
  assign CNT  = cnt_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_reg_bank.sv
// Bench for shift_reg_bank: directed WIDTH=8 cases plus
// random streams on WIDTH=2/8/33 against a behavioural model.
module tb_shift_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r8 = 1'b1, en8 = 1'b0, si8 = 1'b0;
  logic [1:0]  m8 = 2'b00;
  logic [7:0]  d8 = '0;
  logic [7:0]  q8, qn8;
  logic        so8, done8;
  logic [3:0]  cnt8;

  logic        r2 = 1'b1, en2 = 1'b0, si2 = 1'b0;
  logic [1:0]  m2 = 2'b00;
  logic [1:0]  d2 = '0;
  logic [1:0]  q2, qn2;
  logic        so2, done2;
  logic [1:0]  cnt2;

  logic        r33 = 1'b1, en33 = 1'b0, si33 = 1'b0;
  logic [1:0]  m33 = 2'b00;
  logic [32:0] d33 = '0;
  logic [32:0] q33, qn33;
  logic        so33, done33;
  logic [5:0]  cnt33;

  shift_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (
    .CK(clk), .R(r8), .EN(en8), .M(m8), .D(d8), .SI(si8),
    .Q(q8), .QN(qn8), .SO(so8), .CNT(cnt8), .DONE(done8));

  shift_reg_bank #(.WIDTH(2), .RST_VAL(2'b10)) u2 (
    .CK(clk), .R(r2), .EN(en2), .M(m2), .D(d2), .SI(si2),
    .Q(q2), .QN(qn2), .SO(so2), .CNT(cnt2), .DONE(done2));

  shift_reg_bank #(.WIDTH(33), .RST_VAL(33'h1_2345_6789)) u33 (
    .CK(clk), .R(r33), .EN(en33), .M(m33), .D(d33), .SI(si33),
    .Q(q33), .QN(qn33), .SO(so33), .CNT(cnt33), .DONE(done33));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
  endtask

  // Behavioural model: value-level arithmetic on a 64-bit word
  logic [63:0] mq [3];
  int          mc [3];
  logic        md [3];
  bit          mv [3] = '{0, 0, 0};

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic mstep(input int i, input int w,
                       input logic [63:0] rv, input logic r,
                       input logic en, input logic [1:0] m,
                       input logic [63:0] d, input logic si);
    if (r === 1'b1) begin
      mq[i] = rv; mc[i] = 0; md[i] = 1'b0; mv[i] = 1;
    end else begin
      md[i] = 1'b0;
      if (en === 1'b1) begin
        if (m == 2'b01) begin
          mq[i] = d & msk(w); mc[i] = 0;
        end else if (m[1]) begin
          if (m == 2'b10)
            mq[i] = (mq[i] >> 1) | (64'(si) << (w - 1));
          else
            mq[i] = ((mq[i] << 1) | 64'(si)) & msk(w);
          if (mc[i] < w) begin
            mc[i]++;
            if (mc[i] == w) md[i] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    mstep(0, 8,  64'hA5,        r8,  en8,  m8,  64'(d8),  si8);
    mstep(1, 2,  64'h2,         r2,  en2,  m2,  64'(d2),  si2);
    mstep(2, 33, 64'h1_2345_6789, r33, en33, m33, 64'(d33), si33);
  end

  task automatic cmp(input string nm, input int i, input int w,
                     input logic [63:0] q, input logic [63:0] qn,
                     input logic so, input int cnt, input logic dn,
                     input logic [1:0] m);
    logic so_e;
    if (!mv[i]) return;
    so_e = (m == 2'b10) ? mq[i][0] : mq[i][w-1];
    chk({nm, ".Q"},    q,  mq[i]);
    chk({nm, ".QN"},   qn, ~mq[i] & msk(w));
    chk({nm, ".SO"},   64'(so), 64'(so_e));
    chk({nm, ".CNT"},  64'(cnt), 64'(mc[i]));
    chk({nm, ".DONE"}, 64'(dn), 64'(md[i]));
  endtask

  always @(negedge clk) begin
    cmp("w8",  0, 8,  64'(q8),  64'(qn8),  so8,  int'(cnt8),  done8,  m8);
    cmp("w2",  1, 2,  64'(q2),  64'(qn2),  so2,  int'(cnt2),  done2,  m2);
    cmp("w33", 2, 33, 64'(q33), 64'(qn33), so33, int'(cnt33), done33, m33);
  end

  // Small-width instances run random streams throughout
  int rcyc = 0;
  always @(negedge clk) begin
    #1;
    rcyc++;
    r2   = (rcyc < 2) || ($urandom_range(63) == 0);
    en2  = ($urandom_range(3) != 0);
    m2   = 2'($urandom);
    d2   = 2'($urandom);
    si2  = 1'($urandom);
    r33  = (rcyc < 2) || ($urandom_range(127) == 0);
    en33 = ($urandom_range(3) != 0);
    m33  = 2'($urandom);
    d33  = {1'($urandom), 32'($urandom)};
    si33 = 1'($urandom);
  end

  logic so_pre;

  // Called at a negedge; drives, samples SO, returns at next negedge
  task automatic step8(input logic r, input logic en,
                       input logic [1:0] m, input logic [7:0] d,
                       input logic si);
    #1;
    r8 = r; en8 = en; m8 = m; d8 = d; si8 = si;
    #1;
    so_pre = so8;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] so_seq;
    logic [7:0] bits;
    int         pulses;
    @(negedge clk);

    // Reset has priority over load
    step8(1, 1, 2'b01, 8'hFF, 0);
    chk("rst.Q",    64'(q8),    64'hA5);
    chk("rst.QN",   64'(qn8),   64'h5A);
    chk("rst.CNT",  64'(cnt8),  64'd0);
    chk("rst.DONE", 64'(done8), 64'd0);

    // Load 81 then shift right 8 times
    step8(0, 1, 2'b01, 8'h81, 0);
    for (int k = 1; k <= 8; k++) begin
      step8(0, 1, 2'b10, 8'h00, 0);
      so_seq[8-k] = so_pre;
      chk("shr.DONE", 64'(done8), 64'(k == 8));
    end
    chk("shr.SOseq", 64'(so_seq), 64'h81);
    chk("shr.Q",     64'(q8),     64'h00);
    chk("shr.CNT",   64'(cnt8),   64'd8);
    step8(0, 1, 2'b00, 8'h00, 0);
    chk("shr.DONEoff", 64'(done8), 64'd0);

    // Deserialize via shift left
    step8(0, 1, 2'b01, 8'h00, 0);
    bits = 8'b11010010;
    pulses = 0;
    for (int k = 7; k >= 0; k--) begin
      step8(0, 1, 2'b11, 8'h00, bits[k]);
      pulses += int'(done8);
    end
    chk("shl.Q",      64'(q8),   64'hD2);
    chk("shl.pulses", 64'(pulses), 64'd1);
    step8(0, 1, 2'b11, 8'h00, 0);
    chk("shl.satCNT",  64'(cnt8),  64'd8);
    chk("shl.satDONE", 64'(done8), 64'd0);

    // Enable gating
    step8(0, 1, 2'b01, 8'h3C, 0);
    repeat (5) step8(0, 0, 2'b10, 8'h00, 1);
    chk("en.Qhold",   64'(q8),   64'h3C);
    chk("en.CNThold", 64'(cnt8), 64'd0);
    step8(0, 1, 2'b10, 8'h00, 1);
    chk("en.Q",   64'(q8),   64'h9E);
    chk("en.CNT", 64'(cnt8), 64'd1);

    // Reset mid-sequence
    step8(0, 1, 2'b01, 8'h00, 0);
    repeat (3) step8(0, 1, 2'b10, 8'h00, 1);
    step8(1, 1, 2'b10, 8'h00, 1);
    chk("midrst.CNT",  64'(cnt8),  64'd0);
    chk("midrst.DONE", 64'(done8), 64'd0);
    chk("midrst.Q",    64'(q8),    64'hA5);

    // Load after 7 shifts
    step8(0, 1, 2'b01, 8'h00, 0);
    repeat (7) step8(0, 1, 2'b11, 8'h00, 1);
    chk("midld.CNT7", 64'(cnt8), 64'd7);
    step8(0, 1, 2'b01, 8'h55, 0);
    chk("midld.CNT",  64'(cnt8),  64'd0);
    chk("midld.DONE", 64'(done8), 64'd0);
    step8(0, 1, 2'b10, 8'h00, 0);
    chk("midld.DONE2", 64'(done8), 64'd0);

    // Mode switch keeps counting
    step8(0, 1, 2'b01, 8'h00, 0);
    repeat (4) step8(0, 1, 2'b10, 8'h00, 1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step8(0, 1, 2'b11, 8'h00, 0);
      pulses += int'(done8);
    end
    chk("mix.DONE",   64'(done8), 64'd1);
    chk("mix.pulses", 64'(pulses), 64'd1);
    chk("mix.CNT",    64'(cnt8),  64'd8);

    // Random phase for WIDTH=8
    for (int k = 0; k < 10000; k++)
      step8(($urandom_range(63) == 0), ($urandom_range(3) != 0),
            2'($urandom), 8'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
